// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding an 8N1 LSB-first UART transmitter; first start bit drives one cycle after the push edge.
// Backpressure: tx_wait is high while the FIFO is full, and a send during tx_wait is dropped.
module uart_tx_buffer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int BAUD_DIV   = 573
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] data,
  output logic       tx_wait,
  output logic       tx_empty,
  output logic       txd
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int BW    = $clog2(BAUD_DIV);
  localparam logic [BW-1:0]       BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [DEPTH_LOG2:0] FULL      = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_d;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0]   count;
  logic [BW-1:0]         baud_cnt, baud_cnt_d;
  logic [2:0]            bit_idx, bit_idx_d;
  logic [7:0]            shift, shift_d;
  logic                  txd_d, push, pop, baud_done;

  assign tx_wait   = (count == FULL);
  assign tx_empty  = (count == '0) && (state == IDLE);
  assign push      = send && !tx_wait;
  assign baud_done = (baud_cnt == BAUD_LAST);

  // txd_d is the line level for the cycle after this edge, so txd stays a pure register.
  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt + BW'(1);
    bit_idx_d  = bit_idx;
    shift_d    = shift;
    txd_d      = txd;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_d = '0;
        txd_d      = 1'b1;
        if (count != '0) begin
          pop     = 1'b1;
          shift_d = mem[rptr];
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
          state_d    = DATA;
          txd_d      = shift[0];
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            shift_d   = {1'b0, shift[7:1]};
            bit_idx_d = bit_idx + 3'd1;
            txd_d     = shift[1];
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          if (count != '0) begin
            pop     = 1'b1;
            shift_d = mem[rptr];
            state_d = START;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      shift    <= shift_d;
      txd      <= txd_d;
      if (push) wptr <= wptr + DEPTH_LOG2'(1);
      if (pop)  rptr <= rptr + DEPTH_LOG2'(1);
      count <= count + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wptr] <= data;
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Scoreboarded bench: expected bytes queued at send time, a serial-line monitor decodes and compares frames.
module tb_uart_tx_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       send;
  logic [7:0] data;
  logic       tx_wait, tx_empty, txd;

  uart_tx_buffer #(.DEPTH_LOG2(2), .BAUD_DIV(4)) dut (
    .clk(clk), .reset(reset), .send(send), .data(data),
    .tx_wait(tx_wait), .tx_empty(tx_empty), .txd(txd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int frames = 0;
  int starts[$];
  logic [7:0] exp_q[$];
  bit wait_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit accept);
    send = 1'b1;
    data = b;
    if (accept) exp_q.push_back(b);
    tick();
    send = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int limit);
    int n;
    n = 0;
    while (tx_empty !== 1'b1 && n < limit) begin
      if (tx_wait === 1'b1) wait_seen = 1'b1;
      tick();
      n++;
    end
    chk(name, tx_empty, 1);
  endtask

  // Serial monitor: checks every cycle of each 40-cycle frame against the oldest expected byte.
  logic [9:0] mon_frame, mon_got;
  logic [7:0] mon_exp;
  bit mon_ok, mon_abort, mon_has;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && txd === 1'b0) begin
        starts.push_back(cyc);
        mon_has = (exp_q.size() != 0);
        mon_exp = mon_has ? exp_q.pop_front() : 8'h00;
        mon_frame = {1'b1, mon_exp, 1'b0};
        mon_got = '0;
        mon_ok = 1'b1;
        mon_abort = 1'b0;
        for (int k = 0; k < 40 && !mon_abort; k++) begin
          if (k != 0) @(negedge clk);
          if (reset === 1'b1) mon_abort = 1'b1;
          else begin
            if (k % 4 == 1) mon_got[k/4] = txd;
            if (txd !== mon_frame[k/4]) mon_ok = 1'b0;
          end
        end
        if (!mon_abort) begin
          frames++;
          checks++;
          if (!mon_has) begin
            failures++;
            $display("FAIL frame_unexpected: got byte %02h with nothing queued", mon_got[8:1]);
          end else if (!mon_ok) begin
            failures++;
            $display("FAIL frame: got line %b (byte %02h) expected byte %02h", mon_got, mon_got[8:1], mon_exp);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int t0, fr0;
  bit low_seen;

  initial begin : stimulus
    reset = 1'b1;
    send  = 1'b0;
    data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_txd", txd, 1);
    chk("rst_tx_wait", tx_wait, 0);
    chk("rst_tx_empty", tx_empty, 1);

    // Single frame: latency and tx_empty timing.
    tick();
    send_byte(8'hA5, 1);
    t0 = cyc;
    chk("t1_txd_before_load", txd, 1);
    chk("t1_not_empty", tx_empty, 0);
    tick();
    chk("t1_start_bit", txd, 0);
    wait_empty("t1_empty_timeout", 200);
    chk("t1_empty_cycles", cyc - t0, 41);

    // Three back-to-back frames.
    tick();
    starts.delete();
    wait_seen = 1'b0;
    send_byte(8'h01, 1);
    t0 = cyc;
    if (tx_wait === 1'b1) wait_seen = 1'b1;
    send_byte(8'h02, 1);
    if (tx_wait === 1'b1) wait_seen = 1'b1;
    send_byte(8'h03, 1);
    wait_empty("t2_empty_timeout", 400);
    chk("t2_tx_wait_seen", wait_seen, 0);
    chk("t2_total_cycles", cyc - t0, 121);
    chk("t2_frame_count", starts.size(), 3);
    if (starts.size() >= 3) begin
      chk("t2_gap_1_2", starts[1] - starts[0], 40);
      chk("t2_gap_2_3", starts[2] - starts[1], 40);
    end

    // Fill to full, drop a send while full, then drop one on the pop cycle.
    tick();
    fr0 = frames;
    send_byte(8'h10, 1);
    t0 = cyc;
    for (int i = 1; i < 5; i++) send_byte(8'h10 + 8'(i), 1);
    chk("t3_full_after_fifth", tx_wait, 1);
    send_byte(8'h15, 0);
    while (cyc < t0 + 40) tick();
    chk("t4_full_before_pop", tx_wait, 1);
    send = 1'b1;
    data = 8'hEE;
    tick();
    send = 1'b0;
    chk("t4_wait_falls_after_pop", tx_wait, 0);
    wait_empty("t3_empty_timeout", 400);
    chk("t3_frame_count", frames - fr0, 5);

    // Reset mid-frame with bytes queued.
    tick();
    fr0 = frames;
    send_byte(8'hFF, 1);
    t0 = cyc;
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    while (cyc < t0 + 14) tick();
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    chk("t5_txd_after_reset", txd, 1);
    chk("t5_empty_after_reset", tx_empty, 1);
    chk("t5_wait_after_reset", tx_wait, 0);
    low_seen = 1'b0;
    repeat (100) begin
      tick();
      if (txd !== 1'b1) low_seen = 1'b1;
    end
    chk("t5_line_quiet", low_seen, 0);
    chk("t5_no_frames", frames - fr0, 0);
    send_byte(8'h3C, 1);
    wait_empty("t5_empty_timeout", 200);
    chk("t5_new_frame", frames - fr0, 1);

    // Twenty bytes through a four-entry FIFO: pointer wrap.
    tick();
    fr0 = frames;
    for (int i = 0; i < 20; i++) begin
      int n;
      n = 0;
      while (tx_wait === 1'b1 && n < 200) begin
        tick();
        n++;
      end
      chk("t6_flow_timeout", tx_wait, 0);
      send_byte(8'(i), 1);
    end
    wait_empty("t6_empty_timeout", 2000);
    chk("t6_frame_count", frames - fr0, 20);
    chk("t6_scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Output-side counterpart of the input-wait logic: accepts bytes from the OUTPUTB instruction path, queues them in a small FIFO, and serializes them on the UART TX line as 8N1, LSB first.
- Drives tx_wait back to the decoder. The decoder freezes an OUTPUTB while tx_wait is high, the same way INPUTB freezes on rx_wait.
- Sits between the execute stage's output strobe and the board's TXD pin.

Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 bytes (default 16).
- BAUD_DIV, 573: clock cycles per UART bit. Must be at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- send  in  1  enqueue strobe, one pulse per OUTPUTB byte.
- data  in  8  byte to enqueue; sampled when send=1.
- tx_wait  out  1  FIFO full. Combinational from the occupancy count; used by the decoder as its freeze condition.
- tx_empty  out  1  FIFO empty and serializer in IDLE; everything has been sent.
- txd  out  1  serial output line; idles high.

Behaviour:
- Reset (synchronous, at the clk edge while reset=1):
  - count=0, read and write pointers=0, state=IDLE, baud counter=0, bit index=0.
  - txd=1, tx_wait=0, tx_empty=1.
  - Reset during a frame aborts it: txd is 1 from the next edge, and queued bytes are discarded.
- FIFO:
  - Circular buffer of 2^DEPTH_LOG2 x 8 bits, with a (DEPTH_LOG2+1)-bit count.
  - Pointers wrap modulo the depth.
  - tx_wait = (count == 2^DEPTH_LOG2).
- Push: send=1 and tx_wait=0 → write data at wptr, wptr+1, count+1.
  - send=1 while tx_wait=1 is ignored: no write, no state change. This holds even if a pop occurs in the same cycle. The decoder is required never to do this.
- Pop: occurs when the serializer loads a byte (see below) → rptr+1, count-1.
- Simultaneous push and pop with the FIFO not full: both happen and count is unchanged.
- Serializer states:
  - IDLE: txd=1. If count>0: load the shift register with fifo[rptr], pop, clear the baud counter, go to START.
  - START: txd=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for BAUD_DIV cycles per bit, shifting right after each bit. After bit 7 go to STOP.
  - STOP: txd=1 for BAUD_DIV cycles. At the end, if count>0, load/pop the next byte and go directly to START (back-to-back frames, no extra idle bit). Otherwise go to IDLE.
- txd is driven from a register (glitch-free).
  - A full frame is exactly 10*BAUD_DIV cycles of txd.
- Latency:
  - send at edge t into an empty, idle block → byte written at t, load at t+1, txd=0 starting after edge t+1.
- Empty-to-nonempty and full-to-nonfull transitions take effect on the edge after the push or pop. tx_wait deasserts in the cycle after the pop that frees a slot.
- tx_empty = (count==0 && state==IDLE).

Test Plan (BAUD_DIV=4, DEPTH_LOG2=2 unless noted):
1. Reset, then send=1 with data=8'hA5 for one cycle → txd low for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high for 4 cycles. tx_empty returns to 1 exactly 41 cycles after the send edge.
2. Send 8'h01, 8'h02, 8'h03 on consecutive cycles → three back-to-back frames (120 cycles of txd activity, no idle gap), bytes in order, tx_wait never asserted.
3. Send 5 bytes in consecutive cycles (the first is popped at once, so 4 remain queued) → tx_wait=1 after the fifth push. A sixth send while tx_wait=1 is dropped: only 5 frames appear. tx_wait falls the cycle after the second load.
4. FIFO full with a push attempted on the exact cycle the serializer pops (end of STOP) → push dropped, count decrements by 1, next frame carries the oldest queued byte.
5. Assert reset for one cycle in the middle of DATA of byte 8'hFF with 2 bytes queued → txd=1 from the next cycle, tx_empty=1, tx_wait=0, no further frames. A new send of 8'h3C afterwards transmits correctly.
6. Pointer wrap: stream 20 bytes with values 0..19, sending each when tx_wait=0 → received serial sequence is exactly 0..19 in order.
